// File: rtl/mux_nto1_reg.sv
// mux_nto1_reg: N-input, W-bit channel multiplexer with per-channel
// valid/ready handshakes and a one-stage output register.
// Supports fixed-select mode (mode=0) and round-robin arbitration (mode=1).
// Optional feature macro: MUX_PARITY_EN adds a registered even-parity
// output (out_par) that tracks out_data.
module mux_nto1_reg #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*W-1:0]    in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  input  logic [SELW-1:0]   sel,
  input  logic              mode,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef MUX_PARITY_EN
  output logic              out_par,
`endif
  output logic [SELW-1:0]   out_ch
);

  logic            load_en;
  logic [SELW-1:0] rr_ptr;
  logic [SELW-1:0] rr_next;
  logic [SELW-1:0] chosen;
  logic            chosen_ok;
  logic            hi_found;
  logic            lo_found;
  logic [SELW-1:0] hi_idx;
  logic [SELW-1:0] lo_idx;
  logic [W-1:0]    sel_data;
  logic            take;

  // Pick the channel to serve this cycle: the select input in fixed mode,
  // or the first valid channel at or after rr_ptr (wrapping) in round-robin.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the branches below can leave one unassigned and infer a latch.
    load_en   = ~out_valid | out_ready;
    chosen    = sel;
    chosen_ok = 1'b0;
    hi_found  = 1'b0;
    lo_found  = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    if (!mode) begin
      // An out-of-range select matches no channel and so grants nothing.
      for (int i = 0; i < N; i++) begin
        if (sel == SELW'(i)) chosen_ok = 1'b1;
      end
    end else begin
      // Descending scan: the last hit is the lowest index. hi_* is the lowest
      // valid channel at or above rr_ptr; lo_* is the lowest overall, which is
      // the wrapped-around winner when nothing at or above rr_ptr is valid.
      for (int i = N - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          lo_found = 1'b1;
          lo_idx   = SELW'(i);
          if (SELW'(i) >= rr_ptr) begin
            hi_found = 1'b1;
            hi_idx   = SELW'(i);
          end
        end
      end
      chosen    = hi_found ? hi_idx : lo_idx;
      chosen_ok = hi_found | lo_found;
    end
  end

  // Drive ready to the chosen channel only, and route its data to the register.
  always_comb begin
    in_ready = '0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (SELW'(i) == chosen) begin
        in_ready[i] = load_en & chosen_ok & ~rst;
        sel_data    = in_data[i*W +: W];
      end
    end
    take    = |(in_valid & in_ready);
    rr_next = (chosen == SELW'(N - 1)) ? '0 : chosen + 1'b1;
  end

  // Output register and round-robin pointer; reset discards any held word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
`ifdef MUX_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      if (load_en) begin
        if (take) begin
          out_data  <= sel_data;
          out_ch    <= chosen;
          out_valid <= 1'b1;
`ifdef MUX_PARITY_EN
          out_par   <= ^sel_data;
`endif
        end else begin
          out_valid <= 1'b0;
        end
      end
      if (mode && take) rr_ptr <= rr_next;
    end
  end

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Self-checking bench for mux_nto1_reg (N=4, W=8 main instance plus an
// N=3 instance for the out-of-range select case). Expected values come from
// a behavioural model using modular channel arithmetic.
module tb_mux_nto1_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic [1:0]  sel;
  logic        mode, out_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [1:0]  out_ch;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3, in_ready3;
  logic [1:0]  sel3;
  logic        mode3, out_ready3;
  logic [7:0]  out_data3;
  logic        out_valid3;
  logic [1:0]  out_ch3;
`ifdef MUX_PARITY_EN
  logic        out_par, out_par3;
`endif

  int total = 0;
  int bad = 0;

  // Reference model state
  logic       m_valid;
  logic [7:0] m_data;
  logic [1:0] m_ch;
  int         m_ptr;

  mux_nto1_reg #(.N(4), .W(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef MUX_PARITY_EN
    .out_par(out_par),
`endif
    .out_ch(out_ch)
  );

  mux_nto1_reg #(.N(3), .W(8)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .sel(sel3), .mode(mode3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready3),
`ifdef MUX_PARITY_EN
    .out_par(out_par3),
`endif
    .out_ch(out_ch3)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_ready();
    logic [3:0] r;
    int c;
    r = '0;
    if (rst) return r;
    if (m_valid && !out_ready) return r;
    if (!mode) begin
      r[sel] = 1'b1;
      return r;
    end
    for (int k = 0; k < 4; k++) begin
      c = (m_ptr + k) % 4;
      if (in_valid[c]) begin
        r[c] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_ch    = 2'd0;
    m_ptr   = 0;
  endtask

  task automatic model_clock();
    logic [3:0] r;
    r = exp_ready();
    if (rst) begin
      model_reset();
      return;
    end
    if (m_valid && !out_ready) return;
    if ((r & in_valid) != 4'b0000) begin
      for (int c = 0; c < 4; c++) begin
        if (r[c]) begin
          m_data = in_data[c*8 +: 8];
          m_ch   = 2'(c);
        end
      end
      m_valid = 1'b1;
      if (mode) m_ptr = (int'(m_ch) + 1) % 4;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_data = 32'h0; in_valid = 4'b1111; sel = 2'd0; mode = 1'b0; out_ready = 1'b1;
    in_data3 = 24'h0; in_valid3 = 3'b111; sel3 = 2'd0; mode3 = 1'b0; out_ready3 = 1'b1;
    model_reset();
    #3;
    total++;
    if ({out_valid, out_data, out_ch} !== 11'd0)
      $display("FAIL reset_outputs got v=%b d=%h ch=%0d want 0", out_valid, out_data, out_ch);
    if ({out_valid, out_data, out_ch} !== 11'd0) bad++;
    total++;
    if (in_ready !== 4'b0000) begin
      bad++; $display("FAIL reset_ready got %b want 0000", in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    // Load a word, then assert reset mid-cycle while it is held
    sel = 2'd1; in_valid = 4'b0010; in_data = 32'h0000_5A00;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h5A) begin
      bad++; $display("FAIL pre_reset_load got v=%b d=%h want 1 5a", out_valid, out_data);
    end
    out_ready = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    total++;
    if ({out_valid, out_data, out_ch} !== 11'd0 || in_ready !== 4'b0000) begin
      bad++;
      $display("FAIL midstream_reset got v=%b d=%h ch=%0d rdy=%b want all 0",
               out_valid, out_data, out_ch, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 4'b0000;
  endtask

  task automatic test_fixed();
    mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    #1;
    total++;
    if (in_ready !== 4'b0100 || in_ready !== exp_ready()) begin
      bad++; $display("FAIL fixed_ready got %b want 0100", in_ready);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
      bad++; $display("FAIL fixed_out got v=%b d=%h ch=%0d want 1 a5 2", out_valid, out_data, out_ch);
    end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_out_of_range();
    in_data3 = {8'h33, 8'h22, 8'h11}; in_valid3 = 3'b111; sel3 = 2'd0;
    mode3 = 1'b0; out_ready3 = 1'b1;
    tick();
    total++;
    if (out_valid3 !== 1'b1 || out_data3 !== 8'h11 || out_ch3 !== 2'd0) begin
      bad++; $display("FAIL n3_load got v=%b d=%h ch=%0d want 1 11 0", out_valid3, out_data3, out_ch3);
    end
    sel3 = 2'd3;
    #1;
    total++;
    if (in_ready3 !== 3'b000) begin
      bad++; $display("FAIL n3_sel_oor_ready got %b want 000", in_ready3);
    end
    tick();
    total++;
    if (out_valid3 !== 1'b0 || out_data3 !== 8'h11) begin
      bad++; $display("FAIL n3_sel_oor_drop got v=%b d=%h want 0 11", out_valid3, out_data3);
    end
    in_valid3 = 3'b000;
  endtask

  task automatic test_backpressure();
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_data = 32'h0000_0011; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; sel = 2'd1; in_valid = 4'b0010; in_data = 32'h0000_2200;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (in_ready !== 4'b0000) begin
        bad++; $display("FAIL bp_ready cycle %0d got %b want 0000", i, in_ready);
      end
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h11 || out_ch !== 2'd0) begin
        bad++; $display("FAIL bp_hold cycle %0d got v=%b d=%h want 1 11", i, out_valid, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 4'b0010) begin
      bad++; $display("FAIL bp_release_ready got %b want 0010", in_ready);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h22 || out_ch !== 2'd1) begin
      bad++; $display("FAIL bp_no_bubble got v=%b d=%h ch=%0d want 1 22 1", out_valid, out_data, out_ch);
    end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_rr_fairness();
    logic [1:0] seq [6];
    int fires [4];
    seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    fires = '{0, 0, 0, 0};
    pulse_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    in_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    for (int i = 0; i < 6; i++) begin
      #1;
      total++;
      if (in_ready !== exp_ready() || $countones(in_ready) != 1) begin
        bad++; $display("FAIL rr_ready step %0d got %b want %b", i, in_ready, exp_ready());
      end
      if (i < 4) for (int c = 0; c < 4; c++) if (in_ready[c]) fires[c]++;
      tick();
      total++;
      if (out_ch !== seq[i] || out_valid !== 1'b1 || out_data !== m_data) begin
        bad++; $display("FAIL rr_order step %0d got ch=%0d d=%h want ch=%0d d=%h",
                        i, out_ch, out_data, seq[i], m_data);
      end
    end
    total++;
    if (fires[0] != 1 || fires[1] != 1 || fires[2] != 1 || fires[3] != 1) begin
      bad++; $display("FAIL rr_fair got %0d %0d %0d %0d want 1 each", fires[0], fires[1], fires[2], fires[3]);
    end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_rr_skip_wrap();
    logic [3:0] vin [4];
    logic [1:0] want [4];
    vin  = '{4'b0100, 4'b0010, 4'b0001, 4'b1111};
    want = '{2'd2, 2'd1, 2'd0, 2'd1};
    pulse_reset();
    mode = 1'b1; out_ready = 1'b1;
    in_data = {8'h4D, 8'h3C, 8'h2B, 8'h1A};
    for (int i = 0; i < 4; i++) begin
      in_valid = vin[i];
      #1;
      total++;
      if (in_ready !== exp_ready() || in_ready[want[i]] !== 1'b1) begin
        bad++; $display("FAIL rr_skip_ready step %0d got %b want %b", i, in_ready, exp_ready());
      end
      tick();
      total++;
      if (out_ch !== want[i] || out_data !== m_data || out_valid !== 1'b1) begin
        bad++; $display("FAIL rr_skip_wrap step %0d got ch=%0d want ch=%0d", i, out_ch, want[i]);
      end
    end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_parity();
    logic [7:0] words [2];
    logic       pars  [2];
    words = '{8'h07, 8'h03};
    pars  = '{1'b1, 1'b0};
    mode = 1'b0; sel = 2'd0; out_ready = 1'b1; in_valid = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      in_data = {24'h0, words[i]};
      tick();
      total++;
      if (out_data !== words[i]) begin
        bad++; $display("FAIL parity_word %0d got %h want %h", i, out_data, words[i]);
      end
`ifdef MUX_PARITY_EN
      total++;
      if (out_par !== pars[i]) begin
        bad++; $display("FAIL parity_bit %0d got %b want %b", i, out_par, pars[i]);
      end
`else
      if (pars[i] !== ^words[i]) $display("note: parity table entry %0d inconsistent", i);
`endif
    end
    in_valid = 4'b0000;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_data   = $urandom;
      in_valid  = 4'($urandom);
      sel       = 2'($urandom);
      mode      = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      total++;
      if (in_ready !== exp_ready()) begin
        bad++; $display("FAIL rand_ready cycle %0d got %b want %b", i, in_ready, exp_ready());
      end
      tick();
      total++;
      if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_ch !== m_ch))) begin
        bad++; $display("FAIL rand_out cycle %0d got v=%b d=%h ch=%0d want v=%b d=%h ch=%0d",
                        i, out_valid, out_data, out_ch, m_valid, m_data, m_ch);
      end
`ifdef MUX_PARITY_EN
      total++;
      if (m_valid && out_par !== ^m_data) begin
        bad++; $display("FAIL rand_par cycle %0d got %b want %b", i, out_par, ^m_data);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_out_of_range();
    test_backpressure();
    test_rr_fairness();
    test_rr_skip_wrap();
    test_parity();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
